// File: rtl/cdma_pkg.sv
// Shared definitions for the CDMA configuration master: register offsets,
// controller states and completion codes.
package cdma_pkg;

  localparam int SA_OFF_DEF  = 'h18;
  localparam int DA_OFF_DEF  = 'h20;
  localparam int BTT_OFF_DEF = 'h28;
  localparam int SR_OFF_DEF  = 'h04;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_ZLEN = 2'b01,
    ERR_SLV  = 2'b10,
    ERR_TMO  = 2'b11
  } err_code_t;

endpackage

// File: rtl/cdma_cfg_master_wr.sv
// Single AXI4-Lite write: AW and W raised together on start, each dropped after
// its own handshake; the B phase is opened by the controller via resp_phase.
module axil_wr_single
  import cdma_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              resp_phase,
  output logic              req_done,
  output logic              b_fire,
  output logic              b_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  logic aw_done;
  logic w_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (start) begin
      awaddr  <= addr;
      wdata   <= data;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
    end
  end

  // Flags are registered, so a same-cycle AW+W handshake is seen one cycle later.
  assign req_done = aw_done & w_done;
  assign bready   = resp_phase;
  assign b_fire   = bvalid & resp_phase;
  assign b_err    = (bresp != 2'b00);

endmodule

// File: rtl/cdma_cfg_master.sv
// Programs a simple-mode CDMA (SA, DA, BTT) per start request over AXI4-Lite,
// checks every response and optionally polls the status register for idle.
module cdma_cfg_master
  import cdma_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 26,
  parameter int SA_OFF   = SA_OFF_DEF,
  parameter int DA_OFF   = DA_OFF_DEF,
  parameter int BTT_OFF  = BTT_OFF_DEF,
  parameter int SR_OFF   = SR_OFF_DEF,
  parameter int IDLE_BIT = 1,
  parameter bit POLL_EN  = 1'b1,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_en,
  input  logic [DATA_W-1:0] src_addr,
  input  logic [DATA_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  byte_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  state_t            state_q, state_n;
  err_code_t         code_q, code_n;
  logic [1:0]        idx_q, idx_n;
  logic [CNT_W-1:0]  poll_q, poll_n;
  logic              arvalid_q, arvalid_n;
  logic [ADDR_W-1:0] araddr_q, araddr_n;
  logic [DATA_W-1:0] sa_q, da_q;
  logic [LEN_W-1:0]  len_q;
  logic              latch;
  logic              wr_start, wr_req_done, wr_b_fire, wr_b_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sr_idle;

  assign sr_idle = |(rdata & (DATA_W'(1) << IDLE_BIT));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n   = state_q;
    code_n    = code_q;
    idx_n     = idx_q;
    poll_n    = poll_q;
    arvalid_n = arvalid_q;
    araddr_n  = araddr_q;
    latch     = 1'b0;
    wr_start  = 1'b0;
    unique case (state_q)
      IDLE: if (dma_en) begin
        latch  = 1'b1;
        code_n = ERR_NONE;
        idx_n  = 2'd0;
        poll_n = '0;
        if (byte_len == '0) begin
          code_n  = ERR_ZLEN;
          state_n = FINISH;
        end else begin
          wr_start = 1'b1;
          state_n  = WR_REQ;
        end
      end
      WR_REQ: if (wr_req_done) state_n = WR_RESP;
      WR_RESP: if (wr_b_fire) begin
        if (wr_b_err) begin
          code_n  = ERR_SLV;
          state_n = FINISH;
        end else if (idx_q != 2'd2) begin
          idx_n    = idx_q + 2'd1;
          wr_start = 1'b1;
          state_n  = WR_REQ;
        end else if (POLL_EN) begin
          arvalid_n = 1'b1;
          araddr_n  = ADDR_W'(SR_OFF);
          state_n   = RD_REQ;
        end else begin
          state_n = FINISH;
        end
      end
      RD_REQ: if (arready) begin
        arvalid_n = 1'b0;
        state_n   = RD_RESP;
      end
      RD_RESP: if (rvalid) begin
        if (rresp != 2'b00) begin
          code_n  = ERR_SLV;
          state_n = FINISH;
        end else if (sr_idle) begin
          state_n = FINISH;
        end else begin
          poll_n = poll_q + CNT_W'(1);
          if (poll_q + CNT_W'(1) == CNT_W'(POLL_MAX)) begin
            code_n  = ERR_TMO;
            state_n = FINISH;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_REQ;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The first write is launched from IDLE, before the latches hold src_addr.
  always_comb begin
    wr_addr = ADDR_W'(SA_OFF);
    wr_data = (state_q == IDLE) ? src_addr : sa_q;
    case (idx_n)
      2'd1: begin
        wr_addr = ADDR_W'(DA_OFF);
        wr_data = da_q;
      end
      2'd2: begin
        wr_addr = ADDR_W'(BTT_OFF);
        wr_data = DATA_W'(len_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= ERR_NONE;
      idx_q     <= 2'd0;
      poll_q    <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      sa_q      <= '0;
      da_q      <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_n;
      code_q    <= code_n;
      idx_q     <= idx_n;
      poll_q    <= poll_n;
      arvalid_q <= arvalid_n;
      araddr_q  <= araddr_n;
      if (latch) begin
        sa_q  <= src_addr;
        da_q  <= dst_addr;
        len_q <= byte_len;
      end
    end
  end

  axil_wr_single #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wr_start),
    .addr      (wr_addr),
    .data      (wr_data),
    .resp_phase(state_q == WR_RESP),
    .req_done  (wr_req_done),
    .b_fire    (wr_b_fire),
    .b_err     (wr_b_err),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign err      = done && (code_q != ERR_NONE);
  assign err_code = code_q;
  assign arvalid  = POLL_EN & arvalid_q;
  assign araddr   = POLL_EN ? araddr_q : '0;
  assign rready   = POLL_EN & (state_q == RD_RESP);

endmodule

// File: tb/tb_cdma_cfg_master.sv
// Directed bench: instance 0 without polling, instance 1 polling with POLL_MAX=4,
// each attached to a configurable AXI-Lite slave model driven on the falling edge.
module tb_cdma_cfg_master;
  import cdma_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]        dma_en   = '0;
  logic [DATA_W-1:0] src_addr = '0;
  logic [DATA_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  byte_len = '0;
  logic [1:0]        busy_v, done_v, err_v;

  // Slave behaviour knobs, written only by the stimulus block.
  int aw_dly [2]     = '{0, 0};
  int w_dly [2]      = '{0, 0};
  int bad_b [2]      = '{-1, -1};
  int idle_after [2] = '{0, 0};

  int compared   = 0;
  int mismatched = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata = '0;
    logic [1:0]        bresp = '0, rresp = '0, err_code;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    int aw_wait = 0, w_wait = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, ar_bad = 0;
    logic b_ack = 1'b0, r_ack = 1'b0, aw_alone = 1'b0, w_alone = 1'b0;
    logic [31:0] aw_log [8];
    logic [31:0] w_log [8];

    cdma_cfg_master #(
      .POLL_EN (g == 1),
      .POLL_MAX(g == 1 ? 4 : 1024)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dma_en  (dma_en[g]),
      .src_addr(src_addr),
      .dst_addr(dst_addr),
      .byte_len(byte_len),
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .err     (err_v[g]),
      .err_code(err_code),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready)
    );

    // Values set here are what the DUT samples at the following rising edge.
    always @(negedge clk) begin
      if (!rst_n) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        bresp = '0; rresp = '0; rdata = '0; b_ack = 1'b0; r_ack = 1'b0;
        aw_wait = 0; w_wait = 0; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; ar_bad = 0;
        aw_alone = 1'b0; w_alone = 1'b0;
      end else begin
        if (b_ack) begin
          bvalid = 1'b0; b_ack = 1'b0;
        end else if (bvalid && bready) begin
          b_ack = 1'b1;
        end else if (!bvalid && aw_n > b_n && w_n > b_n) begin
          bvalid = 1'b1;
          bresp  = (b_n == bad_b[g]) ? 2'b10 : 2'b00;
          b_n++;
          b_ack  = bready;
        end

        if (awvalid && !wvalid) aw_alone = 1'b1;
        if (wvalid && !awvalid) w_alone = 1'b1;

        if (awvalid) begin
          if (aw_wait == aw_dly[g]) begin
            awready = 1'b1;
            if (aw_n < 8) aw_log[aw_n] = 32'(awaddr);
            aw_n++; aw_wait = 0;
          end else begin
            awready = 1'b0; aw_wait++;
          end
        end else begin
          awready = 1'b0; aw_wait = 0;
        end

        if (wvalid) begin
          if (w_wait == w_dly[g]) begin
            wready = 1'b1;
            if (w_n < 8) w_log[w_n] = wdata;
            w_n++; w_wait = 0;
          end else begin
            wready = 1'b0; w_wait++;
          end
        end else begin
          wready = 1'b0; w_wait = 0;
        end

        if (r_ack) begin
          rvalid = 1'b0; r_ack = 1'b0;
        end else if (rvalid && rready) begin
          r_ack = 1'b1;
        end else if (!rvalid && ar_n > r_n) begin
          rvalid = 1'b1;
          rresp  = 2'b00;
          rdata  = (r_n >= idle_after[g]) ? 32'h0000_0002 : 32'hFFFF_FFFD;
          r_n++;
          r_ack  = rready;
        end

        if (arvalid) begin
          arready = 1'b1;
          if (araddr != 10'h004) ar_bad++;
          ar_n++;
        end else begin
          arready = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the falling edge of cycle N+1, where N is the start cycle.
  task automatic start_xfer(input int g, input logic [31:0] sa, input logic [31:0] da,
                            input logic [LEN_W-1:0] len, output int t0);
    @(negedge clk);
    src_addr  = sa;
    dst_addr  = da;
    byte_len  = len;
    dma_en[g] = 1'b1;
    t0        = cyc;
    @(negedge clk);
    dma_en[g] = 1'b0;
  endtask

  // Latency of done relative to the start cycle, or -1 if the budget expires.
  task automatic wait_done(input int g, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (done_v[g]) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int t0;
    int lat;

    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy_v), 0);
    check("rst_done",      32'(done_v), 0);
    check("rst_err",       32'(err_v), 0);
    check("rst_code0",     32'(u[0].err_code), 0);
    check("rst_code1",     32'(u[1].err_code), 0);
    check("rst_awvalid",   32'(u[0].awvalid), 0);
    check("rst_wvalid",    32'(u[0].wvalid), 0);
    check("rst_awaddr",    32'(u[0].awaddr), 0);
    check("rst_wdata",     u[0].wdata, 0);
    check("rst_bready",    32'(u[0].bready), 0);
    check("rst_arvalid",   32'(u[1].arvalid), 0);
    check("rst_araddr",    32'(u[1].araddr), 0);
    rst_n = 1'b1;

    // Zero-wait, no polling; a start pulse while busy must be ignored.
    check("t1_busy_pre", 32'(busy_v[0]), 0);
    start_xfer(0, 32'h1000, 32'h2000, 26'd64, t0);
    check("t1_awvalid_n1", 32'(u[0].awvalid), 1);
    check("t1_wvalid_n1",  32'(u[0].wvalid), 1);
    check("t1_busy_n1",    32'(busy_v[0]), 1);
    repeat (2) @(negedge clk);
    src_addr  = 32'hDEAD_0000;
    byte_len  = '0;
    dma_en[0] = 1'b1;
    @(negedge clk);
    dma_en[0] = 1'b0;
    wait_done(0, t0, lat);
    check("t1_latency", lat, 10);
    check("t1_err",     32'(err_v[0]), 0);
    check("t1_code",    32'(u[0].err_code), 0);
    check("t1_busy_done", 32'(busy_v[0]), 1);
    @(negedge clk);
    check("t1_done_after", 32'(done_v[0]), 0);
    check("t1_busy_after", 32'(busy_v[0]), 0);
    repeat (5) @(negedge clk);
    check("t1_aw_count", u[0].aw_n, 3);
    check("t1_w_count",  u[0].w_n, 3);
    check("t1_aw0", u[0].aw_log[0], 32'h18);
    check("t1_aw1", u[0].aw_log[1], 32'h20);
    check("t1_aw2", u[0].aw_log[2], 32'h28);
    check("t1_w0",  u[0].w_log[0], 32'h1000);
    check("t1_w1",  u[0].w_log[1], 32'h2000);
    check("t1_w2",  u[0].w_log[2], 32'd64);
    check("t1_no_ar", u[0].ar_n, 0);

    // AW held back three cycles behind W.
    do_reset();
    aw_dly[0] = 3;
    start_xfer(0, 32'h1000, 32'h2000, 26'd64, t0);
    wait_done(0, t0, lat);
    check("t2a_done", 32'(lat > 0), 1);
    check("t2a_err",  32'(err_v[0]), 0);
    check("t2a_w_drop_aw_held", 32'(u[0].aw_alone), 1);
    check("t2a_aw_count", u[0].aw_n, 3);
    check("t2a_w2", u[0].w_log[2], 32'd64);
    check("t2a_aw1", u[0].aw_log[1], 32'h20);

    // W held back three cycles behind AW.
    do_reset();
    aw_dly[0] = 0;
    w_dly[0]  = 3;
    start_xfer(0, 32'h1000, 32'h2000, 26'd64, t0);
    wait_done(0, t0, lat);
    check("t2b_done", 32'(lat > 0), 1);
    check("t2b_err",  32'(err_v[0]), 0);
    check("t2b_aw_drop_w_held", 32'(u[0].w_alone), 1);
    check("t2b_w_count", u[0].w_n, 3);
    check("t2b_w1", u[0].w_log[1], 32'h2000);
    w_dly[0] = 0;

    // Slave error on the DA write: BTT never written.
    do_reset();
    bad_b[0] = 1;
    start_xfer(0, 32'h1000, 32'h2000, 26'd64, t0);
    wait_done(0, t0, lat);
    check("t3_latency", lat, 7);
    check("t3_err",  32'(err_v[0]), 1);
    check("t3_code", 32'(u[0].err_code), 32'(ERR_SLV));
    repeat (6) @(negedge clk);
    check("t3_aw_count", u[0].aw_n, 2);
    check("t3_code_held", 32'(u[0].err_code), 32'(ERR_SLV));
    bad_b[0] = -1;

    // Polling: idle seen on the third status read.
    do_reset();
    idle_after[1] = 2;
    start_xfer(1, 32'h3000, 32'h4000, 26'd128, t0);
    wait_done(1, t0, lat);
    check("t4_latency", lat, 16);
    check("t4_err",  32'(err_v[1]), 0);
    check("t4_code", 32'(u[1].err_code), 0);
    check("t4_ar_count", u[1].ar_n, 3);
    check("t4_ar_addr_bad", u[1].ar_bad, 0);
    check("t4_w2", u[1].w_log[2], 32'd128);

    // Polling timeout after four reads.
    do_reset();
    idle_after[1] = 100;
    start_xfer(1, 32'h3000, 32'h4000, 26'd128, t0);
    wait_done(1, t0, lat);
    check("t5_latency", lat, 18);
    check("t5_err",  32'(err_v[1]), 1);
    check("t5_code", 32'(u[1].err_code), 32'(ERR_TMO));
    check("t5_ar_count", u[1].ar_n, 4);

    // Zero length: no traffic, done and err in the next cycle.
    do_reset();
    start_xfer(0, 32'h1000, 32'h2000, 26'd0, t0);
    check("t6_done", 32'(done_v[0]), 1);
    check("t6_err",  32'(err_v[0]), 1);
    check("t6_code", 32'(u[0].err_code), 32'(ERR_ZLEN));
    check("t6_awvalid", 32'(u[0].awvalid), 0);
    @(negedge clk);
    check("t6_done_after", 32'(done_v[0]), 0);
    check("t6_busy_after", 32'(busy_v[0]), 0);
    check("t6_aw_count", u[0].aw_n, 0);
    check("t6_w_count",  u[0].w_n, 0);

    // Reset in the middle of WR_REQ.
    aw_dly[0] = 5;
    start_xfer(0, 32'h1000, 32'h2000, 26'd64, t0);
    @(negedge clk);
    check("t7_awvalid_held", 32'(u[0].awvalid), 1);
    check("t7_awaddr_held",  32'(u[0].awaddr), 32'h18);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_awvalid", 32'(u[0].awvalid), 0);
    check("t7_wvalid",  32'(u[0].wvalid), 0);
    check("t7_awaddr",  32'(u[0].awaddr), 0);
    check("t7_wdata",   u[0].wdata, 0);
    check("t7_busy",    32'(busy_v[0]), 0);
    check("t7_done",    32'(done_v[0]), 0);
    check("t7_bready",  32'(u[0].bready), 0);
    rst_n = 1'b1;
    aw_dly[0] = 0;

    // Normal operation resumes after the mid-transaction reset.
    start_xfer(0, 32'h5000, 32'h6000, 26'd4, t0);
    wait_done(0, t0, lat);
    check("t8_latency", lat, 10);
    check("t8_w0", u[0].w_log[0], 32'h5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cdma_cfg_master.md
# cdma_cfg_master

AXI4-Lite master that programs a simple-mode CDMA engine for one transfer per start request. It latches a source address, destination address and byte count, then writes the SA, DA and BTT registers in order. AW and W are handshaken independently, and each B response is checked. Optionally it polls the status register until the engine reports idle. It sits between the core's DMA request logic and the CDMA AXI-Lite slave port, and adds response checking, completion reporting and parametrised offsets and widths.

## Interface
- ADDR_W, 10, AXI-Lite address width
- DATA_W, 32, data/address payload width
- LEN_W, 26, valid bits of byte_len (upper BTT bits written 0)
- SA_OFF / DA_OFF / BTT_OFF / SR_OFF, 'h18 / 'h20 / 'h28 / 'h04, register offsets
- IDLE_BIT, 1, SR bit meaning engine idle
- POLL_EN, 1, 1 = poll SR after BTT write; 0 = done after BTT B response
- POLL_MAX, 1024, poll read limit before timeout error
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- dma_en  in  1  start request, sampled only in IDLE
- src_addr, dst_addr  in  DATA_W  transfer addresses
- byte_len  in  LEN_W  transfer length in bytes
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: transfer failed
- err_code  out  2  00 ok, 01 zero length, 10 slave error response, 11 poll timeout; held until next start
- awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready  AXI-Lite write channels (ADDR_W, DATA_W, 2-bit resp)
- araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI-Lite read channels (tied inactive when POLL_EN=0)

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH. A 2-bit index selects the write target: 0 = SA, 1 = DA, 2 = BTT.
- IDLE, dma_en=1:
  - Latch all three inputs and clear err_code.
  - If byte_len==0: go to FINISH with code 01 and issue no bus traffic.
  - Otherwise: index=0, go to WR_REQ.
- WR_REQ:
  - awvalid and wvalid rise together. awaddr and wdata are selected by index; BTT data is zero-extended.
  - Each valid drops independently after its own valid&ready cycle (tracked by aw_done/w_done flags).
  - Go to WR_RESP once both handshakes are complete, including when both occur in the same cycle.
- WR_RESP:
  - bready=1. On bvalid, bresp≠00 goes to FINISH with code 10.
  - Otherwise index<2 increments and returns to WR_REQ.
  - Index 2 goes to RD_REQ if POLL_EN, else FINISH.
- RD_REQ: arvalid=1, araddr=SR_OFF, held until arready.
- RD_RESP: rready=1. On rvalid:
  - rresp≠00 goes to FINISH with code 10.
  - rdata[IDLE_BIT]=1 goes to FINISH with code 00.
  - Otherwise increment the poll counter. Reaching POLL_MAX goes to FINISH with code 11; else back to RD_REQ.
- FINISH: done=1 and err=(code≠00) for one cycle, then IDLE.
- dma_en outside IDLE is ignored. Latched inputs stay stable throughout the transaction.

## Timing
- Reset values:
  - State IDLE, index 0, poll counter 0.
  - All valid/ready outputs 0; awaddr, wdata and araddr 0.
  - busy, done and err 0; err_code 00.
- awaddr, wdata and araddr are registered and stable while their valid is high. No valid ever drops without its handshake, except on reset.
- Start in cycle N: awvalid/wvalid=1 in N+1.
- With zero-wait slave (ready always 1, bvalid one cycle after W): each register write takes 3 cycles. Done arrives at N+10 with POLL_EN=0.
- Zero-length start: done=err=1 at N+1.
- busy: 1 from N+1 through the done cycle inclusive.
- Reset asserted mid-transaction: all outputs return to reset values next edge. Outstanding slave responses are not tracked.

## Structure
- Shared package cdma_pkg:
  - Register offset constants.
  - The state enum.
  - err_code encodings (ERR_NONE, ERR_ZLEN, ERR_SLV, ERR_TMO).
- Sub-module axil_wr_single: one AW+W+B transaction with independent AW/W handshakes. Instantiated once and driven by index.
- Read path stays inline.

## Test plan
- Zero-wait slave, POLL_EN=0, src 0x1000, dst 0x2000, len 64:
  - Writes in order: 0x18←0x1000, 0x20←0x2000, 0x28←64.
  - done, err=0 at N+10.
- awready delayed 3 cycles vs wready, then reversed:
  - wvalid drops after its handshake while awvalid is held.
  - Exactly three writes occur, same data.
- bresp=10 on DA write:
  - No BTT write.
  - done, err=1, err_code=10.
- POLL_EN=1, SR idle bit 0 for two reads then 1:
  - Exactly three AR handshakes at 0x04.
  - done with err_code=00.
- POLL_MAX=4, idle bit never set: four reads, then done, err_code=11.
- Other checks:
  - byte_len=0: no valids, done/err at N+1.
  - dma_en pulsed while busy is ignored.
  - rst_n low during WR_REQ returns everything to reset values at the next edge.
